// File: rtl/dly_line_ctrl.sv
// dly_line_ctrl: programmable delay line over a MAX_DLY-entry ring buffer.
// A request on cfg_vld/cfg_dly selects a delay D of 1..MAX_DLY. The line
// then refills for D cycles (busy=1) and afterwards streams each
// {din_vld, din} out exactly D cycles later.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cfg_vld, cfg_dly  delay request; the handshake completes when cfg_rdy=1
//   cfg_rdy           high in IDLE and RUN, low while refilling
//   cfg_err           one-cycle pulse after a request with an illegal delay
//   din, din_vld      input stream, sampled on every clock
//   dout, dout_vld    delayed stream, registered, zero unless in RUN
//   busy              high while refilling (FILL)
//   cur_dly           delay currently in force, 0 after reset
module dly_line_ctrl #(
    parameter int DWID    = 10,
    parameter int MAX_DLY = 16,
    parameter int AWID    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_vld,
    input  logic [AWID:0]   cfg_dly,
    output logic            cfg_rdy,
    output logic            cfg_err,
    input  logic [DWID-1:0] din,
    input  logic            din_vld,
    output logic [DWID-1:0] dout,
    output logic            dout_vld,
    output logic            busy,
    output logic [AWID:0]   cur_dly
);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    localparam logic [AWID:0] MAX_D = (AWID+1)'(MAX_DLY);

    state_t          state, state_d;
    logic [AWID:0]   cnt, cnt_d;
    logic [AWID:0]   cur_d;
    logic [AWID-1:0] wr_ptr;
    logic [AWID-1:0] rd_idx;
    logic            dly_ok, accept, reject;

    // Ring of {din_vld, din}; deliberately not reset, since stale entries
    // are never read outside RUN.
    logic [DWID:0] mem [MAX_DLY];

    assign cfg_rdy = (state != FILL);
    assign busy    = (state == FILL);
    assign dly_ok  = (cfg_dly != '0) && (cfg_dly <= MAX_D);
    assign accept  = cfg_vld && cfg_rdy && dly_ok;
    assign reject  = cfg_vld && cfg_rdy && !dly_ok;

    // The sample from D edges ago sits at wr_ptr-D. For D=MAX_DLY this is
    // wr_ptr itself; the read sees the old entry before this edge's write.
    assign rd_idx = wr_ptr - cur_dly[AWID-1:0];

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cur_d   = cur_dly;
        case (state)
            FILL: begin
                cnt_d = cnt + 1'b1;
                if (cnt == cur_dly - 1'b1)
                    state_d = RUN;
            end
            default: ;
        endcase
        // Acceptance can only occur in IDLE or RUN (cfg_rdy), and it
        // restarts the refill from either state.
        if (accept) begin
            state_d = FILL;
            cnt_d   = '0;
            cur_d   = cfg_dly;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_dly <= '0;
            wr_ptr  <= '0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            cur_dly <= cur_d;
            wr_ptr  <= wr_ptr + 1'b1;
            cfg_err <= reject;
        end
    end

    always_ff @(posedge clk) begin
        mem[wr_ptr] <= {din_vld, din};
    end

    // Output registers are zeroed outside RUN. On an accepting edge in RUN
    // they are zeroed too, which drops samples still in flight under the
    // old delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            dout_vld <= 1'b0;
        end else if (state == RUN && !accept) begin
            {dout_vld, dout} <= mem[rd_idx];
        end else begin
            dout     <= '0;
            dout_vld <= 1'b0;
        end
    end

endmodule

// File: doc/dly_line_ctrl.md
DLY_LINE_CTRL -- requirements
Module: dly_line_ctrl

Interface
REQ-001 SHALL have parameter DWID, default 10, data width in bits.
REQ-002 SHALL have parameter MAX_DLY, default 16, ring depth and maximum delay in cycles; it SHALL be a power of two and at least 2.
REQ-003 SHALL have parameter AWID, default 4, equal to log2(MAX_DLY).
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cfg_vld  input  1  new delay request.
REQ-007 cfg_dly  input  AWID+1  requested delay D; legal range 1..MAX_DLY.
REQ-008 cfg_rdy  output  1  controller can accept a request.
REQ-009 cfg_err  output  1  one-cycle pulse when a request carries an illegal value.
REQ-010 din  input  DWID  stream data, sampled every clock.
REQ-011 din_vld  input  1  qualifier for din.
REQ-012 dout  output  DWID  delayed data, registered.
REQ-013 dout_vld  output  1  delayed qualifier, registered.
REQ-014 busy  output  1  high while the line is refilling.
REQ-015 cur_dly  output  AWID+1  delay currently in force; 0 means none.

Function
REQ-016 Storage SHALL be a ring of MAX_DLY entries of {din_vld, din}, written every clock at wr_ptr; wr_ptr increments modulo MAX_DLY every clock in all states.
REQ-017 FSM states SHALL be IDLE, FILL and RUN; busy = (state==FILL).
REQ-018 cfg_rdy SHALL be 1 in IDLE and RUN and 0 in FILL.
REQ-019 A request is accepted at an edge where cfg_vld=1, cfg_rdy=1 and 1<=cfg_dly<=MAX_DLY; call that edge k and D=cfg_dly.
REQ-020 On acceptance: cur_dly<=D, fill counter<=0, state<=FILL, from IDLE or RUN alike.
REQ-021 If cfg_vld=1 and cfg_rdy=1 with cfg_dly=0 or cfg_dly>MAX_DLY: cfg_err=1 for exactly the following cycle; state, cur_dly and outputs unchanged.
REQ-022 If cfg_vld=1 in FILL, the request is ignored (no error, no state change); the requester holds it until cfg_rdy=1.
REQ-023 FILL SHALL last exactly D cycles (after edges k..k+D-1); the counter increments each FILL cycle and the state becomes RUN at edge k+D.
REQ-024 In RUN, the dout/dout_vld driven after edge t SHALL equal the din/din_vld sampled at edge t-D: latency exactly D cycles, including D=MAX_DLY, with correct pointer wrap.
REQ-025 dout_vld SHALL be 1 only for samples taken at edge k+1 or later; the first possibly valid output appears after edge k+1+D.
REQ-026 In IDLE and FILL, dout SHALL be 0 and dout_vld SHALL be 0.
REQ-027 If the delay is reconfigured in RUN, samples in flight under the old delay SHALL be discarded: dout_vld=0 through FILL, no duplicated or reordered output.
REQ-028 If din_vld=0 for a sample, the matching output SHALL have dout_vld=0; dout then carries the stored din unchanged.

Reset
REQ-029 On rst=1, independent of clk: state=IDLE, wr_ptr=0, fill counter=0, cur_dly=0, dout=0, dout_vld=0, cfg_err=0. Hence busy=0 and cfg_rdy=1.
REQ-030 Ring contents need not be reset; REQ-026 and REQ-025 SHALL mask any stale data.
REQ-031 rst asserted mid-FILL or mid-RUN SHALL abort immediately to the REQ-029 values; after release, no output is valid until a new request completes FILL.

Verification
REQ-032 Reset, then din_vld=1 and din=cycle count for 20 cycles with no request -> dout_vld=0, dout=0, cfg_rdy=1, cur_dly=0 throughout.
REQ-033 Accept D=3 at edge k, then drive din=k+1, k+2, ... with din_vld=1 -> busy=1 for 3 cycles; the first dout_vld=1 appears after edge k+4 with dout=k+1; each later output equals din from 3 cycles earlier.
REQ-034 D=16 (MAX_DLY) with a 40-cycle ramp -> each output equals the input from 16 cycles earlier across two wr_ptr wraps, with no gap.
REQ-035 In RUN with D=5, request D=2 -> dout_vld=0 for the 2 FILL cycles plus the pipeline gap; it then resumes with 2-cycle latency and no old-delay sample appears.
REQ-036 Request D=0 and then D=17 -> each produces a 1-cycle cfg_err pulse, cur_dly is unchanged, and the state stays in RUN/IDLE; a request during FILL is held off with cfg_rdy=0 and accepted on the first cycle of RUN.
REQ-037 Assert rst for 1 cycle during FILL with D=8 -> outputs, cur_dly and busy go to 0 at once; after release, state is IDLE and cfg_rdy=1.
